// File: rtl/frame_pkg.sv
// Shared constants and types for the receive-side frame path.
package frame_pkg;

   localparam logic [7:0] FRAME_START = 8'h06;
   localparam logic [7:0] FRAME_END   = 8'h07;
   localparam logic [7:0] ESC_VAL     = 8'h14;
   localparam logic [7:0] ESC_XOR     = 8'h20;

   // Payload composition of a full-size frame
   localparam int unsigned PREAMBLE_BYTES = 7;
   localparam int unsigned DATA_BYTES     = 64;
   localparam int unsigned NONCE_BYTES    = 12;

   typedef enum logic [1:0] {
      OKAY        = 2'd0,
      ERROR       = 2'd1,
      FATAL_ERROR = 2'd2
   } confirm_e;

   typedef enum logic [1:0] {
      FT_PREAMBLE = 2'd0,
      FT_DATA     = 2'd1,
      FT_NONCE    = 2'd2
   } frame_type_e;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_SHORT   = 3'd1;
   localparam logic [2:0] ERR_OVF     = 3'd2;
   localparam logic [2:0] ERR_TMO     = 3'd3;
   localparam logic [2:0] ERR_ESC     = 3'd4;
   localparam logic [2:0] ERR_RESTART = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ESC  = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic       valid;
      logic [2:0] code;
   } rx_err_t;

endpackage

// File: rtl/frame_rx_timeout.sv
// Inter-byte idle timer; strobes expiry on the last idle clock of the window.
module frame_rx_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_expire_c
);

   localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned LAST = TIMEOUT_CYCLES - 1;

   logic [TW-1:0] r_timer;

   assign o_expire_c = i_enable && !i_clear && (r_timer == TW'(LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (!i_enable || i_clear || o_expire_c) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TW'(1);
      end
   end

endmodule

// File: rtl/frame_rx_deframer.sv
// Byte-stuffed frame receiver: hunts for the start flag, unescapes, assembles
// a fixed-size payload and reports framing faults as error codes.
module frame_rx_deframer
   import frame_pkg::*;
#(
   parameter int unsigned FRAME_BYTES    = 83,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 rx_byte,
   input  logic                       rx_valid,
   output logic [0:FRAME_BYTES*8-1]   fout,
   output logic                       fout_valid,
   output logic                       err_valid,
   output logic [2:0]                 err_code,
   output logic                       busy
);

   localparam int unsigned FW = FRAME_BYTES * 8;
   localparam int unsigned CW = $clog2(FRAME_BYTES + 1);
   localparam int unsigned SW = $clog2(FW);

   rx_state_e       r_state;
   rx_state_e       w_state_nxt;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic [0:FW-1]   r_shadow;
   logic            w_store;
   logic [7:0]      w_store_byte;
   logic [SW-1:0]   w_base;
   logic            w_done;
   rx_err_t         w_err;
   logic            w_expire;
   logic            w_in_frame;
   logic            w_full;

   assign w_in_frame = (r_state != ST_IDLE);
   assign w_full     = (r_count == CW'(FRAME_BYTES));
   assign w_base     = SW'({r_count, 3'b000});

   frame_rx_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (w_in_frame),
      .i_clear    (rx_valid),
      .o_expire_c (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_store      = 1'b0;
      w_store_byte = rx_byte;
      w_done       = 1'b0;
      w_err        = '0;
      case (r_state)
         ST_IDLE: begin
            if (rx_valid && (rx_byte == FRAME_START)) begin
               w_state_nxt = ST_DATA;
               w_count_nxt = '0;
            end
         end
         ST_DATA, ST_ESC: begin
            if (w_expire) begin
               w_err.valid = 1'b1;
               w_err.code  = ERR_TMO;
               w_state_nxt = ST_IDLE;
            end else if (rx_valid) begin
               if (rx_byte == FRAME_START) begin
                  // A start flag always restarts assembly; only the reported cause differs
                  w_err.valid = 1'b1;
                  w_err.code  = (r_state == ST_ESC) ? ERR_ESC : ERR_RESTART;
                  w_state_nxt = ST_DATA;
                  w_count_nxt = '0;
               end else if (rx_byte == FRAME_END) begin
                  w_state_nxt = ST_IDLE;
                  if (r_state == ST_ESC) begin
                     w_err.valid = 1'b1;
                     w_err.code  = ERR_ESC;
                  end else if (w_full) begin
                     w_done = 1'b1;
                  end else begin
                     w_err.valid = 1'b1;
                     w_err.code  = ERR_SHORT;
                  end
               end else if ((r_state == ST_DATA) && (rx_byte == ESC_VAL)) begin
                  w_state_nxt = ST_ESC;
               end else if (w_full) begin
                  w_err.valid = 1'b1;
                  w_err.code  = ERR_OVF;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_store      = 1'b1;
                  w_store_byte = (r_state == ST_ESC) ? (rx_byte ^ ESC_XOR) : rx_byte;
                  w_count_nxt  = r_count + CW'(1);
                  w_state_nxt  = ST_DATA;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shadow assembly and registered outputs; fout only moves on a good frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_shadow   <= '0;
         fout       <= '0;
         fout_valid <= 1'b0;
         err_valid  <= 1'b0;
         err_code   <= ERR_NONE;
         busy       <= 1'b0;
      end else begin
         r_count    <= w_count_nxt;
         fout_valid <= w_done;
         err_valid  <= w_err.valid;
         busy       <= (w_state_nxt != ST_IDLE);
         if (w_store) begin
            r_shadow[w_base +: 8] <= w_store_byte;
         end
         if (w_done) begin
            fout <= r_shadow;
         end
         if (w_err.valid) begin
            err_code <= w_err.code;
         end
      end
   end

endmodule

// File: tb/tb_frame_rx_deframer.sv
// Directed bench for frame_rx_deframer with a scoreboard of expected frame/error events.
module tb_frame_rx_deframer;

   localparam int unsigned FB  = 4;
   localparam int unsigned TMO = 16;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic [7:0]        rx_byte  = 8'h00;
   logic              rx_valid = 1'b0;
   logic [0:FB*8-1]   fout;
   logic              fout_valid;
   logic              err_valid;
   logic [2:0]        err_code;
   logic              busy;

   always #5 clk = ~clk;

   frame_rx_deframer #(
      .FRAME_BYTES    (FB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .fout       (fout),
      .fout_valid (fout_valid),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .busy       (busy)
   );

   typedef struct {
      bit          is_err;
      logic [2:0]  code;
      logic [31:0] data;
      int          when;
   } exp_t;

   exp_t        q[$];
   int          nchecks = 0;
   int          nerr    = 0;
   int          ncnt    = 0;
   logic [31:0] hold    = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nchecks++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_frame(input logic [31:0] d);
      exp_t e;
      e.is_err = 1'b0;
      e.code   = 3'd0;
      e.data   = d;
      e.when   = ncnt + 1;
      q.push_back(e);
   endtask

   task automatic expect_err(input logic [2:0] c);
      exp_t e;
      e.is_err = 1'b1;
      e.code   = c;
      e.data   = '0;
      e.when   = ncnt + 1;
      q.push_back(e);
   endtask

   // Output monitor: every pulse must match the head of the scoreboard
   always @(negedge clk) begin : mon
      exp_t e;
      ncnt = ncnt + 1;
      if (fout_valid || err_valid) begin
         chk("excl_pulse", 32'(fout_valid & err_valid), 32'd0);
         if (q.size() == 0) begin
            chk("unexpected_pulse", {30'b0, fout_valid, err_valid}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("pulse_cycle", ncnt, e.when);
            chk("pulse_kind", 32'(err_valid), 32'(e.is_err));
            if (e.is_err) begin
               chk("err_code", 32'(err_code), 32'(e.code));
               chk("fout_hold", fout, hold);
            end else begin
               chk("fout", fout, e.data);
               hold = e.data;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fout", fout, 32'd0);
      chk("rst_fout_valid", 32'(fout_valid), 32'd0);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Junk while hunting is dropped silently
      send(8'h55); send(8'h07); send(8'h14);
      chk("idle_busy", 32'(busy), 32'd0);

      // Plain good frame
      send(8'h06);
      chk("data_busy", 32'(busy), 32'd1);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h07); expect_frame(32'h11223344);
      idle(2);

      // Escaped bytes
      send(8'h06); send(8'h14); send(8'h26); send(8'h14); send(8'h27);
      send(8'h14); send(8'h34); send(8'h55);
      send(8'h07); expect_frame(32'h06071455);
      idle(2);

      // Short frame
      send(8'h06); send(8'h11); send(8'h22);
      send(8'h07); expect_err(3'd1);
      idle(2);

      // Restart on a second start flag
      send(8'h06); send(8'hAA);
      send(8'h06); expect_err(3'd5);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h07); expect_frame(32'h01020304);
      idle(2);

      // Overflow
      send(8'h06); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h05); expect_err(3'd2);
      chk("ovf_busy", 32'(busy), 32'd0);
      idle(2);

      // Escape followed by end flag
      send(8'h06); send(8'h14);
      send(8'h07); expect_err(3'd4);
      idle(2);

      // Escape followed by start flag restarts
      send(8'h06); send(8'h11); send(8'h14);
      send(8'h06); expect_err(3'd4);
      send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
      send(8'h07); expect_frame(32'h0A0B0C0D);
      idle(2);

      // Gap one clock short of the timeout survives
      send(8'h06); send(8'h11);
      idle(TMO - 1);
      send(8'h22); send(8'h33); send(8'h44);
      send(8'h07); expect_frame(32'h11223344);
      idle(2);

      // Full timeout, then a stray end flag is ignored
      send(8'h06); send(8'h11);
      idle(TMO); expect_err(3'd3);
      chk("tmo_busy", 32'(busy), 32'd0);
      send(8'h07);
      idle(4);

      // Reset mid-frame
      send(8'h06); send(8'h11); send(8'h22);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      hold = '0;
      chk("mid_rst_fout", fout, 32'd0);
      chk("mid_rst_err_code", 32'(err_code), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valids", {30'b0, fout_valid, err_valid}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send(8'h06); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
      send(8'h07); expect_frame(32'hA1B2C3D4);

      for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
      idle(3);
      chk("scoreboard_drain", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
